// File: rtl/prio_arbiter_rr_if.sv
// Request/grant bundle between request sources, the arbiter and the grant consumer.
// The master side drives requests and readiness; the slave side (the arbiter) returns the grant.
interface prio_arbiter_rr_if #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
);
  logic            en;
  logic [N-1:0]    req;
  logic            grant_ready;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic [N-1:0]    grant_onehot;
  logic            any_req;

  modport master (
    output en, req, grant_ready,
    input  grant_valid, grant_idx, grant_onehot, any_req
  );

  modport slave (
    input  en, req, grant_ready,
    output grant_valid, grant_idx, grant_onehot, any_req
  );
endinterface

// File: rtl/prio_arbiter_rr.sv
// N-input arbiter with a registered grant and valid/ready handshake.
// MODE=0 gives fixed priority (MSB wins); MODE=1 is round-robin, where the last winner becomes lowest priority.
module prio_arbiter_rr #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N),
  parameter int MODE = 0
) (
  input logic               clk,
  input logic               rst_n,
  prio_arbiter_rr_if.slave  bus
);

  logic            r_valid;
  logic [IDXW-1:0] r_idx;
  logic [N-1:0]    r_onehot;
  logic            r_any;
  logic [IDXW-1:0] r_ptr;

  logic            w_hs;
  logic            w_load;
  logic [IDXW-1:0] w_ptr;
  logic            w_found;
  logic [IDXW-1:0] w_win;
  logic [IDXW-1:0] w_j;
  int              w_jn;

  assign w_hs   = r_valid && bus.grant_ready;
  assign w_load = bus.en && (!r_valid || bus.grant_ready);

  // A grant consumed this cycle already counts as the newest winner for the same-cycle reload.
  assign w_ptr = ((MODE != 0) && w_hs) ? r_idx : r_ptr;

  // Search ptr-1 downward with wrap; the pointer position itself is checked last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_jn    = 0;
    w_j     = '0;
    for (int k = 1; k <= N; k++) begin
      w_jn = int'(w_ptr) + N - k;
      if (w_jn >= N) w_jn = w_jn - N;
      w_j = IDXW'(w_jn);
      if (!w_found && bus.req[w_j]) begin
        w_found = 1'b1;
        w_win   = w_j;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_any    <= 1'b0;
      r_ptr    <= '0;
    end else begin
      if ((MODE != 0) && w_hs) r_ptr <= r_idx;
      if (w_load) begin
        r_valid  <= w_found;
        r_idx    <= w_found ? w_win : '0;
        r_onehot <= w_found ? ({{(N-1){1'b0}}, 1'b1} << w_win) : '0;
        r_any    <= w_found;
      end else if (w_hs) begin
        // Consumed with arbitration disabled: drop valid, keep the last index.
        r_valid  <= 1'b0;
        r_onehot <= '0;
      end
    end
  end

  assign bus.grant_valid  = r_valid;
  assign bus.grant_idx    = r_idx;
  assign bus.grant_onehot = r_onehot;
  assign bus.any_req      = r_any;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr: fixed-priority N=8, round-robin N=8 and round-robin N=5 instances
// driven in parallel and compared against a priority-list reference model.
module tb_prio_arbiter_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_arbiter_rr_if #(.N(8)) if_f ();
  prio_arbiter_rr_if #(.N(8)) if_r ();
  prio_arbiter_rr_if #(.N(5)) if_5 ();

  prio_arbiter_rr #(.N(8), .MODE(0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(if_f));
  prio_arbiter_rr #(.N(8), .MODE(1)) u_rr  (.clk(clk), .rst_n(rst_n), .bus(if_r));
  prio_arbiter_rr #(.N(5), .MODE(1)) u_rr5 (.clk(clk), .rst_n(rst_n), .bus(if_5));

  typedef struct {
    int v;
    int idx;
    int oh;
    int any;
    int last;
  } mst_t;

  mst_t m [3];
  int   nn [3] = '{8, 8, 5};
  int   md [3] = '{0, 1, 1};

  int         errs  = 0;
  int         total = 0;
  logic       t_en  = 1'b0;
  logic       t_rdy = 1'b0;
  logic [7:0] t_req = 8'h00;

  // Reference: the most recently served source is lowest priority; the priority list
  // runs downward from just below it, wrapping. Fixed mode never moves the "last" marker off 0.
  function automatic mst_t step(mst_t s, int n, int mode, int en, int req, int rdy);
    mst_t r;
    int   p;
    int   hs;
    r  = s;
    hs = (s.v != 0 && rdy != 0) ? 1 : 0;
    p  = (mode != 0 && hs != 0) ? s.idx : s.last;
    if (mode != 0 && hs != 0) r.last = s.idx;
    if (en != 0 && (s.v == 0 || rdy != 0)) begin
      r.v = 0; r.idx = 0; r.oh = 0; r.any = 0;
      for (int k = 1; k <= n; k++) begin
        int j;
        j = (p - k + n) % n;
        if (r.v == 0 && ((req >> j) & 1) != 0) begin
          r.v = 1; r.idx = j; r.oh = 1 << j; r.any = 1;
        end
      end
    end else if (hs != 0) begin
      r.v  = 0;
      r.oh = 0;
    end
    return r;
  endfunction

  task automatic rst_models();
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0};
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(logic en, logic rdy, logic [7:0] req);
    t_en = en; t_rdy = rdy; t_req = req;
    if_f.en = en; if_f.grant_ready = rdy; if_f.req = req;
    if_r.en = en; if_r.grant_ready = rdy; if_r.req = req;
    if_5.en = en; if_5.grant_ready = rdy; if_5.req = req[4:0];
  endtask

  task automatic cmp_all();
    chk("fix.valid",  32'(if_f.grant_valid),  m[0].v);
    chk("fix.idx",    32'(if_f.grant_idx),    m[0].idx);
    chk("fix.onehot", 32'(if_f.grant_onehot), m[0].oh);
    chk("fix.any",    32'(if_f.any_req),      m[0].any);
    chk("rr8.valid",  32'(if_r.grant_valid),  m[1].v);
    chk("rr8.idx",    32'(if_r.grant_idx),    m[1].idx);
    chk("rr8.onehot", 32'(if_r.grant_onehot), m[1].oh);
    chk("rr8.any",    32'(if_r.any_req),      m[1].any);
    chk("rr5.valid",  32'(if_5.grant_valid),  m[2].v);
    chk("rr5.idx",    32'(if_5.grant_idx),    m[2].idx);
    chk("rr5.onehot", 32'(if_5.grant_onehot), m[2].oh);
    chk("rr5.any",    32'(if_5.any_req),      m[2].any);
  endtask

  // One clock: advance the model on the edge with the inputs present there, compare on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) rst_models();
    else
      for (int i = 0; i < 3; i++)
        m[i] = step(m[i], nn[i], md[i], int'(t_en), int'(t_req) & ((1 << nn[i]) - 1), int'(t_rdy));
    @(negedge clk);
    cmp_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_models();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00);
    rst_models();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmp_all();

    // Reset asserted in the middle of a cycle while a grant is pending
    drive(1'b1, 1'b0, 8'h24);
    cyc();
    chk("t1.pre_valid", 32'(if_f.grant_valid), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    rst_models();
    chk("t1.valid", 32'(if_f.grant_valid), 0);
    chk("t1.idx", 32'(if_f.grant_idx), 0);
    chk("t1.onehot", 32'(if_f.grant_onehot), 0);
    chk("t1.any", 32'(if_f.any_req), 0);
    chk("t1.rr_valid", 32'(if_r.grant_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h00);
    cyc();
    chk("t1.post_valid", 32'(if_f.grant_valid), 0);

    // Fixed priority, one cycle after each request change
    drive(1'b1, 1'b1, 8'h01); cyc();
    chk("t2.idx0", 32'(if_f.grant_idx), 0);
    drive(1'b1, 1'b1, 8'h16); cyc();
    chk("t2.idx4", 32'(if_f.grant_idx), 4);
    drive(1'b1, 1'b1, 8'h80); cyc();
    chk("t2.idx7", 32'(if_f.grant_idx), 7);
    chk("t2.oh80", 32'(if_f.grant_onehot), 32'h80);

    // Backpressure holds the grant while requests change
    drive(1'b1, 1'b1, 8'h24); cyc();
    chk("t3.idx5", 32'(if_f.grant_idx), 5);
    drive(1'b1, 1'b0, 8'h01);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t3.hold", 32'(if_f.grant_idx), 5);
    end
    drive(1'b1, 1'b1, 8'h01); cyc();
    chk("t3.idx0", 32'(if_f.grant_idx), 0);

    // Round-robin rotation from ptr=0
    do_reset();
    drive(1'b1, 1'b1, 8'hFF);
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("t4.rot", 32'(if_r.grant_idx), (k < 8) ? 7 - k : 7);
    end
    drive(1'b1, 1'b1, 8'h81);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t4.alt", 32'(if_r.grant_idx), (k % 2 == 0) ? 0 : 7);
    end

    // Arbitration disabled: grant consumed, nothing reloaded
    drive(1'b0, 1'b1, 8'hFF);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t5.nogrant", 32'(if_f.grant_valid), 0);
    end
    drive(1'b1, 1'b1, 8'hFF); cyc();
    chk("t5.resume", 32'(if_f.grant_valid), 1);

    // Empty request, then non-power-of-two wrap
    drive(1'b1, 1'b1, 8'h00); cyc();
    chk("t6.valid", 32'(if_f.grant_valid), 0);
    chk("t6.any", 32'(if_f.any_req), 0);
    chk("t6.onehot", 32'(if_f.grant_onehot), 0);
    do_reset();
    drive(1'b1, 1'b1, 8'h11);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t6.n5", 32'(if_5.grant_idx), (k == 1) ? 0 : 4);
    end

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [7:0] rq;
      case ($urandom_range(0, 3))
        0: rq = 8'h00;
        1: rq = 8'(1 << $urandom_range(0, 7));
        default: rq = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) rq = t_req;
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, rq);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
